alu_mdu: RTL
============

Name: alu_mdu

Overview:
- Next-generation RV32IM execute unit: RV32I register and immediate ALU ops plus the M extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Width is parametrised; 1-cycle registered ALU path and a fixed-latency iterative multiply/divide path share one valid/ready input handshake and one result register.
- Sits between the register-file read stage and writeback. The immediate is already muxed onto b by the decode stage.

Parameters:
- BITS, 32, datapath width (≥8, power of two); shift amounts use b[$clog2(BITS)-1:0].

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and instr present.
- in_ready  output  1  unit can accept; high only in IDLE.
- instr  input  32  raw instruction; decode uses {instr[31:25], instr[14:12], instr[6:0]}.
- a  input  BITS  rs1.
- b  input  BITS  rs2 or sign-extended immediate.
- out_valid  output  1  one-cycle pulse; res and out_illegal valid.
- res  output  BITS  result.
- out_illegal  output  1  the accepted instr was not a decodable ALU/M op.

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, res=0, out_illegal=0, iteration counter=0.
- A transfer occurs on an edge where in_valid && in_ready. There is no output backpressure; the consumer must take the out_valid pulse.
- ALU op (opcode 0110011 with funct7 0000000/0100000, or opcode 0010011) accepted at edge N:
  - res registered at edge N; out_valid=1 for the cycle after N.
  - State stays IDLE, so back-to-back accepts give one result per cycle.
- Decode:
  - funct3 000 ADD/SUB (SUB only R-type with instr[30]=1); ADDI ignores instr[31:25].
  - 001 SLL/SLLI (SLLI requires funct7=0).
  - 010 SLT/SLTI signed; 011 SLTU/SLTIU unsigned (distinct codes).
  - 100 XOR/XORI; 110 OR/ORI; 111 AND/ANDI.
  - 101 SRL/SRLI when instr[30]=0, SRA/SRAI (arithmetic, sign-filled) when instr[30]=1.
- Illegal encoding: out_illegal=1, res=0, 1-cycle latency like the ALU path.
- M op (opcode 0110011, funct7 0000001). FSM: IDLE -> CALC -> FIX -> IDLE.
  - Accept at edge N: latch operand magnitudes and signs per variant, load counter=BITS-1, go to CALC.
  - CALC: one shift-add (mul) or restoring shift-subtract (div) step per edge. After the step where counter==0, go to FIX.
  - FIX, edge N+BITS+1: apply sign correction, write res, pulse out_valid, return to IDLE.
  - Fixed latency is BITS+1 edges after accept; in_ready=0 during CALC and FIX.
- Mul results:
  - MUL returns the low BITS bits of the product.
  - MULH is signed×signed high; MULHSU is signed a × unsigned b high; MULHU is unsigned high. All use the 2·BITS product.
- Div special cases (same fixed latency, no early exit):
  - b==0: DIV/DIVU quotient=all-ones; REM/REMU=a.
  - Signed overflow (a=MIN, b=−1): DIV=MIN, REM=0.
  - Remainder takes the sign of the dividend.
- Reset mid-operation: on the rst edge, return to IDLE and discard the operation. No out_valid pulse is produced for it.
- in_valid while busy is ignored, and nothing is latched. The producer holds the instruction until in_ready.

Decomposition:
- alu_pkg holds:
  - Opcode constants OP_REG=0110011 and OP_IMM=0010011.
  - FUNCT7_BASE, FUNCT7_ALT, FUNCT7_MULDIV.
  - funct3 codes for each ALU and M op.
  - Enum of internal op selects.
  - FSM state enum {IDLE, CALC, FIX}.
- Sub-module mdu_iter is the iterative multiply/divide engine, with its own start/done and the sign handling. The top level keeps decode, the ALU datapath, the handshake and the result register.

Test Plan:
- Reset, then ADD a=5,b=7 accepted at edge N -> out_valid the cycle after N, res=12, out_illegal=0; then SUB 5−7 -> res=0xFFFFFFFE.
- SRA a=0x80000000, b=4 -> 0xF8000000; SRL same operands -> 0x08000000; SLTIU a=1, b=0xFFFFFFFF -> 1; SLTI same operands -> 0.
- MULH a=0xFFFFFFFF, b=0xFFFFFFFF -> 0 with out_valid exactly 33 edges after accept; MULHU same operands -> 0xFFFFFFFE; MUL same operands -> 1.
- DIV a=−7, b=2 -> −3; REM -> −1; DIVU a=7, b=0 -> 0xFFFFFFFF; REMU -> 7; DIV 0x80000000 / −1 -> 0x80000000, REM -> 0.
- Back-to-back: ADDI, DIVU, ADDI with in_valid held -> in_ready low for 33 cycles, the second ADDI is accepted only after the DIVU result, and results come out in order.
- rst asserted mid-DIV (cycle 10 of CALC) -> no out_valid for the DIV; in_ready=1 the next cycle; an illegal funct7=1111111 R-type -> out_illegal=1, res=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the alu_mdu execute unit.
// Holds the instruction-field constants, the internal op-select and FSM
// enums, and small decode helpers used by the top level and by mdu_iter.
package alu_pkg;

  localparam logic [6:0] OP_REG        = 7'b0110011;
  localparam logic [6:0] OP_IMM        = 7'b0010011;
  localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // ALU funct3 codes
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // M-extension funct3 codes; bit 2 set means a divide-class op
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_MDU, ALU_ILL
  } op_sel_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } state_e;

  // Map an ALU funct3 to an op select; alt distinguishes SUB/SRA.
  function automatic op_sel_e alu_sel(input logic [2:0] f3, input logic alt);
    op_sel_e sel;
    case (f3)
      F3_ADD:  sel = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  sel = ALU_SLL;
      F3_SLT:  sel = ALU_SLT;
      F3_SLTU: sel = ALU_SLTU;
      F3_XOR:  sel = ALU_XOR;
      F3_SR:   sel = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   sel = ALU_OR;
      F3_AND:  sel = ALU_AND;
      default: sel = ALU_ILL;
    endcase
    return sel;
  endfunction

  // Operand a is treated as signed for MULH, MULHSU, DIV and REM.
  function automatic logic m_signed_a(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // Operand b is treated as signed for MULH, DIV and REM.
  function automatic logic m_signed_b(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide engine.
// Works on operand magnitudes: BITS shift-add steps for multiplies, BITS
// restoring shift-subtract steps for divides, then one FIX cycle applying
// the sign correction. Latency from start to done is BITS+1 edges.
// Ports: clk, rst (sync, active high), start_i (accept an op), f3_i (M funct3),
//        a_i/b_i (operands), busy_o (not IDLE), done_o (FIX cycle),
//        res_o (corrected result, valid while done_o).
module mdu_iter
  import alu_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      f3_i,
  input  logic [BITS-1:0] a_i,
  input  logic [BITS-1:0] b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [BITS-1:0] res_o
);

  localparam int CW = $clog2(BITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(BITS - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  // mul: {0, partial product high, multiplier/low}; div: {remainder, quotient}
  logic [2*BITS:0]   acc_q, acc_d;
  logic [BITS-1:0]   opb_q, opb_d;   // multiplicand or divisor magnitude
  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d;   // negate product / quotient
  logic              rneg_q, rneg_d; // negate remainder (dividend sign)
  logic              dz_q, dz_d;     // divide by zero

  logic              a_neg_s, b_neg_s;
  logic [BITS-1:0]   a_mag_s, b_mag_s;
  logic [BITS:0]     mul_hi_s, div_diff_s;
  logic [2*BITS:0]   mul_step_s, div_shift_s, div_step_s;
  logic [2*BITS-1:0] prod_s;
  logic [BITS-1:0]   quo_s, rem_s;

  assign a_neg_s = m_signed_a(f3_i) & a_i[BITS-1];
  assign b_neg_s = m_signed_b(f3_i) & b_i[BITS-1];
  assign a_mag_s = a_neg_s ? ({BITS{1'b0}} - a_i) : a_i;
  assign b_mag_s = b_neg_s ? ({BITS{1'b0}} - b_i) : b_i;

  // Multiply step: conditionally add multiplicand to the high half, then shift right.
  assign mul_hi_s   = {1'b0, acc_q[2*BITS-1:BITS]} + (acc_q[0] ? {1'b0, opb_q} : {(BITS+1){1'b0}});
  assign mul_step_s = {1'b0, mul_hi_s, acc_q[BITS-1:1]};

  // Divide step: shift left, trial-subtract divisor; MSB of the difference is the borrow.
  assign div_shift_s = {acc_q[2*BITS-1:0], 1'b0};
  assign div_diff_s  = div_shift_s[2*BITS:BITS] - {1'b0, opb_q};
  assign div_step_s  = div_diff_s[BITS] ? div_shift_s : {div_diff_s, div_shift_s[BITS-1:1], 1'b1};

  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == FIX);

  // Sign correction and result selection for the FIX cycle
  always_comb begin
    prod_s = neg_q ? ({(2*BITS){1'b0}} - acc_q[2*BITS-1:0]) : acc_q[2*BITS-1:0];
    // A zero divisor keeps the all-ones quotient regardless of operand signs
    quo_s  = (neg_q && !dz_q) ? ({BITS{1'b0}} - acc_q[BITS-1:0]) : acc_q[BITS-1:0];
    rem_s  = rneg_q ? ({BITS{1'b0}} - acc_q[2*BITS-1:BITS]) : acc_q[2*BITS-1:BITS];
    case (f3_q)
      F3_MUL:                       res_o = prod_s[BITS-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: res_o = prod_s[2*BITS-1:BITS];
      F3_DIV, F3_DIVU:              res_o = quo_s;
      F3_REM, F3_REMU:              res_o = rem_s;
      default:                      res_o = {BITS{1'b0}};
    endcase
  end

  // Next-state logic for the IDLE -> CALC -> FIX sequence and datapath registers
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    f3_d    = f3_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = CALC;
          cnt_d   = CNT_MAX;
          f3_d    = f3_i;
          neg_d   = a_neg_s ^ b_neg_s;
          rneg_d  = a_neg_s;
          dz_d    = (b_i == {BITS{1'b0}});
          opb_d   = f3_i[2] ? b_mag_s : a_mag_s;
          acc_d   = {{(BITS+1){1'b0}}, (f3_i[2] ? a_mag_s : b_mag_s)};
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        acc_d = f3_q[2] ? div_step_s : mul_step_s;
        cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == {CW{1'b0}}) begin
          state_d = FIX;
        end else begin
          state_d = CALC;
        end
      end
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
      acc_q   <= {(2*BITS+1){1'b0}};
      opb_q   <= {BITS{1'b0}};
      f3_q    <= 3'b000;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      f3_q    <= f3_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// RV32IM execute unit: decode, single-cycle ALU, handshake and result register,
// with multiply/divide delegated to mdu_iter.
// Ports: clk, rst (sync, active high), in_valid/in_ready (input handshake),
//        instr (raw instruction), a (rs1), b (rs2 or immediate),
//        out_valid (one-cycle result pulse), res (result), out_illegal.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  output logic            out_valid,
  output logic [BITS-1:0] res,
  output logic            out_illegal
);

  localparam int SHW = $clog2(BITS);

  logic [6:0]      opcode_s, funct7_s;
  logic [2:0]      funct3_s;
  logic [SHW-1:0]  shamt_s;
  logic            unused_instr_s;
  op_sel_e         op_sel_s;
  logic [BITS-1:0] alu_res_s;
  logic            accept_s, mdu_start_s, mdu_busy_s, mdu_done_s;
  logic [BITS-1:0] mdu_res_s;
  logic [BITS-1:0] res_q, res_d;
  logic            out_valid_q, out_valid_d;
  logic            illegal_q, illegal_d;

  assign opcode_s       = instr[6:0];
  assign funct3_s       = instr[14:12];
  assign funct7_s       = instr[31:25];
  assign unused_instr_s = ^{instr[24:15], instr[11:7]};
  assign shamt_s        = b[SHW-1:0];

  assign in_ready    = ~mdu_busy_s;
  assign accept_s    = in_valid & in_ready;
  assign mdu_start_s = accept_s & (op_sel_s == ALU_MDU);

  // Instruction decode into an internal op select
  always_comb begin
    op_sel_s = ALU_ILL;
    case (opcode_s)
      OP_REG: begin
        if (funct7_s == FUNCT7_MULDIV) begin
          op_sel_s = ALU_MDU;
        end else if (funct7_s == FUNCT7_BASE) begin
          op_sel_s = alu_sel(funct3_s, 1'b0);
        end else if ((funct7_s == FUNCT7_ALT) && ((funct3_s == F3_ADD) || (funct3_s == F3_SR))) begin
          op_sel_s = alu_sel(funct3_s, 1'b1);
        end else begin
          op_sel_s = ALU_ILL;
        end
      end
      OP_IMM: begin
        // ADDI has no SUB form; its upper bits are immediate
        if (funct3_s == F3_ADD) begin
          op_sel_s = ALU_ADD;
        end else if ((funct3_s == F3_SLL) && (funct7_s != FUNCT7_BASE)) begin
          op_sel_s = ALU_ILL;
        end else begin
          op_sel_s = alu_sel(funct3_s, instr[30]);
        end
      end
      default: op_sel_s = ALU_ILL;
    endcase
  end

  // Single-cycle ALU datapath
  always_comb begin
    alu_res_s = {BITS{1'b0}};
    case (op_sel_s)
      ALU_ADD:  alu_res_s = a + b;
      ALU_SUB:  alu_res_s = a - b;
      ALU_SLL:  alu_res_s = a << shamt_s;
      ALU_SLT:  alu_res_s = {{(BITS-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: alu_res_s = {{(BITS-1){1'b0}}, (a < b)};
      ALU_XOR:  alu_res_s = a ^ b;
      ALU_SRL:  alu_res_s = a >> shamt_s;
      ALU_SRA:  alu_res_s = $signed(a) >>> shamt_s;
      ALU_OR:   alu_res_s = a | b;
      ALU_AND:  alu_res_s = a & b;
      default:  alu_res_s = {BITS{1'b0}};
    endcase
  end

  mdu_iter #(
    .BITS(BITS)
  ) u_mdu (
    .clk     (clk),
    .rst     (rst),
    .start_i (mdu_start_s),
    .f3_i    (funct3_s),
    .a_i     (a),
    .b_i     (b),
    .busy_o  (mdu_busy_s),
    .done_o  (mdu_done_s),
    .res_o   (mdu_res_s)
  );

  // Result register next state; MDU completion and a new accept never coincide
  always_comb begin
    out_valid_d = 1'b0;
    res_d       = res_q;
    illegal_d   = illegal_q;
    if (mdu_done_s) begin
      out_valid_d = 1'b1;
      res_d       = mdu_res_s;
      illegal_d   = 1'b0;
    end else if (accept_s && (op_sel_s != ALU_MDU)) begin
      out_valid_d = 1'b1;
      res_d       = alu_res_s;
      illegal_d   = (op_sel_s == ALU_ILL);
    end else begin
      out_valid_d = 1'b0;
    end
  end

  // Output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      res_q       <= {BITS{1'b0}};
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign res         = res_q;
  assign out_illegal = illegal_q;

endmodule
